// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings and main-decoder ALUOp classes for the
// decode stage and its combinational decoder.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_LUI    = 2'b11;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational RV32I ALU control decoder: op/funct3/funct7_5/ALUOp to an
// ALU control word plus an illegal-encoding flag.
module alu_decode_comb
    import alu_ctrl_pkg::*;
#(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_OP_WIDTH   = 2,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic [OP_WIDTH-1:0]       op_i,
    input  logic [FUNCT3_WIDTH-1:0]   funct3_i,
    input  logic                      funct7_5_i,
    input  logic [ALU_OP_WIDTH-1:0]   alu_op_i,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_o,
    output logic                      illegal_o
);

    logic [2:0] f3;
    logic       op5;
    logic       unused_op;
    alu_ctrl_e  ctrl;
    logic       ill;

    assign f3        = funct3_i[2:0];
    assign op5       = op_i[5];
    assign unused_op = ^op_i;

    always_comb begin
        ctrl = ALU_ADD;
        ill  = 1'b0;
        case (alu_op_i)
            ALU_OP_WIDTH'(ALUOP_MEM): ctrl = ALU_ADD;
            ALU_OP_WIDTH'(ALUOP_BRANCH): begin
                case (f3)
                    3'b000, 3'b001: ctrl = ALU_SUB;
                    3'b100, 3'b101: ctrl = ALU_SLT;
                    3'b110, 3'b111: ctrl = ALU_SLTU;
                    default:        ill  = 1'b1;
                endcase
            end
            ALU_OP_WIDTH'(ALUOP_ARITH): begin
                case (f3)
                    3'b000:  ctrl = (op5 && funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = funct7_5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
                // Bit 30 only has meaning for sub/sra; on R-type anything else is reserved.
                if (op5 && funct7_5_i && f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
                if (f3 == 3'b001 && funct7_5_i) ill = 1'b1;
            end
            ALU_OP_WIDTH'(ALUOP_LUI): ctrl = ALU_PASSB;
            default: ctrl = ALU_ADD;
        endcase
        if (ill) ctrl = ALU_ADD;
    end

    assign alu_ctrl_o = ALU_CTRL_WIDTH'(ctrl);
    assign illegal_o  = ill;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage: valid/ready output register with a one-entry
// skid buffer, flush, and a saturating stall counter.
module alu_decode_stage
    import alu_ctrl_pkg::*;
#(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_OP_WIDTH   = 2,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int TAG_WIDTH      = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic                      funct7_5,
    input  logic [ALU_OP_WIDTH-1:0]   ALUOp,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic                      illegal,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    logic [ALU_CTRL_WIDTH-1:0] dec_ctrl;
    logic                      dec_ill;
    logic                      accept;

    logic                      main_vld_q,  main_vld_d;
    logic [ALU_CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic                      main_ill_q,  main_ill_d;
    logic [TAG_WIDTH-1:0]      main_tag_q,  main_tag_d;
    logic                      skid_vld_q,  skid_vld_d;
    logic [ALU_CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic                      skid_ill_q,  skid_ill_d;
    logic [TAG_WIDTH-1:0]      skid_tag_q,  skid_tag_d;
    logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;

    alu_decode_comb #(
        .OP_WIDTH      (OP_WIDTH),
        .FUNCT3_WIDTH  (FUNCT3_WIDTH),
        .ALU_OP_WIDTH  (ALU_OP_WIDTH),
        .ALU_CTRL_WIDTH(ALU_CTRL_WIDTH)
    ) u_dec (
        .op_i      (op),
        .funct3_i  (funct3),
        .funct7_5_i(funct7_5),
        .alu_op_i  (ALUOp),
        .alu_ctrl_o(dec_ctrl),
        .illegal_o (dec_ill)
    );

    // Ready depends only on registered skid state, so out_ready never reaches in_ready.
    assign in_ready = rst_n && !skid_vld_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_ill_d  = main_ill_q;
        main_tag_d  = main_tag_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_ill_d  = skid_ill_q;
        skid_tag_d  = skid_tag_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_ready) begin
            skid_vld_d = 1'b0;
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_ill_d  = skid_ill_q;
                main_tag_d  = skid_tag_q;
            end else if (accept) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = dec_ctrl;
                main_ill_d  = dec_ill;
                main_tag_d  = in_tag;
            end else begin
                main_vld_d  = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = dec_ctrl;
            skid_ill_d  = dec_ill;
            skid_tag_d  = in_tag;
        end

        if (main_vld_q && !out_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_ill_q  <= 1'b0;
            main_tag_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_ill_q  <= 1'b0;
            skid_tag_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_ill_q  <= main_ill_d;
            main_tag_q  <= main_tag_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_ill_q  <= skid_ill_d;
            skid_tag_q  <= skid_tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid  = main_vld_q;
    assign ALUControl = main_ctrl_q;
    assign illegal    = main_ill_q;
    assign out_tag    = main_tag_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode table, handshake, skid,
// flush, stall-counter saturation and mid-transfer reset.
module tb_alu_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [1:0] ALUOp;
    logic [4:0] in_tag;
    logic       flush;
    logic       out_ready;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [3:0]  ALUControl, ALUControl4;
    logic        illegal,   illegal4;
    logic [4:0]  out_tag,   out_tag4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_LD  = 7'b0000011;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct3(funct3), .funct7_5(funct7_5), .ALUOp(ALUOp),
        .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .ALUControl(ALUControl), .illegal(illegal),
        .out_tag(out_tag), .stall_cnt(stall_cnt)
    );

    alu_decode_stage #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .funct3(funct3), .funct7_5(funct7_5), .ALUOp(ALUOp),
        .in_tag(in_tag), .flush(flush), .out_valid(out_valid4),
        .out_ready(out_ready), .ALUControl(ALUControl4), .illegal(illegal4),
        .out_tag(out_tag4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ctrl, input logic ill,
                           input logic [4:0] tg);
        logic [31:0] obs, exp;
        obs = {21'd0, out_valid, illegal, ALUControl, out_tag};
        exp = {21'd0, 1'b1, ill, ctrl, tg};
        chk(tag, obs, exp);
    endtask

    task automatic drv(input logic v, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [1:0] aop, input logic [4:0] tg);
        in_valid = v;
        op       = o;
        funct3   = f3;
        funct7_5 = f7;
        ALUOp    = aop;
        in_tag   = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drv(1'b0, 7'd0, 3'd0, 1'b0, 2'd0, 5'd0);
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", {ALUControl, illegal, out_tag}, 0);
        chk("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // R-type stream, one result per cycle
        out_ready = 1'b1;
        drv(1'b1, OP_R, 3'b000, 1'b1, 2'b10, 5'd1); tick(); chk_out("r_sub", 4'd1, 1'b0, 5'd1);
        drv(1'b1, OP_R, 3'b000, 1'b0, 2'b10, 5'd2); tick(); chk_out("r_add", 4'd0, 1'b0, 5'd2);
        drv(1'b1, OP_R, 3'b101, 1'b1, 2'b10, 5'd3); tick(); chk_out("r_sra", 4'd9, 1'b0, 5'd3);
        drv(1'b1, OP_R, 3'b101, 1'b0, 2'b10, 5'd4); tick(); chk_out("r_srl", 4'd8, 1'b0, 5'd4);
        drv(1'b1, OP_R, 3'b111, 1'b0, 2'b10, 5'd5); tick(); chk_out("r_and", 4'd2, 1'b0, 5'd5);
        drv(1'b1, OP_R, 3'b100, 1'b1, 2'b10, 5'd6); tick(); chk_out("r_xor_f7_ill", 4'd0, 1'b1, 5'd6);

        // I-type
        drv(1'b1, OP_I, 3'b000, 1'b1, 2'b10, 5'd7); tick(); chk_out("addi_f7", 4'd0, 1'b0, 5'd7);
        drv(1'b1, OP_I, 3'b101, 1'b1, 2'b10, 5'd8); tick(); chk_out("srai", 4'd9, 1'b0, 5'd8);
        drv(1'b1, OP_I, 3'b001, 1'b1, 2'b10, 5'd9); tick(); chk_out("slli_f7_ill", 4'd0, 1'b1, 5'd9);
        drv(1'b1, OP_I, 3'b110, 1'b1, 2'b10, 5'd10); tick(); chk_out("ori_f7", 4'd3, 1'b0, 5'd10);

        // Branches, lui, memory
        drv(1'b1, OP_BR, 3'b000, 1'b0, 2'b01, 5'd11); tick(); chk_out("br_000", 4'd1, 1'b0, 5'd11);
        drv(1'b1, OP_BR, 3'b100, 1'b0, 2'b01, 5'd12); tick(); chk_out("br_100", 4'd5, 1'b0, 5'd12);
        drv(1'b1, OP_BR, 3'b110, 1'b0, 2'b01, 5'd13); tick(); chk_out("br_110", 4'd6, 1'b0, 5'd13);
        drv(1'b1, OP_BR, 3'b011, 1'b0, 2'b01, 5'd14); tick(); chk_out("br_011_ill", 4'd0, 1'b1, 5'd14);
        drv(1'b1, OP_LUI, 3'b000, 1'b0, 2'b11, 5'd15); tick(); chk_out("lui", 4'd10, 1'b0, 5'd15);
        drv(1'b1, OP_LD, 3'b010, 1'b0, 2'b00, 5'd16); tick(); chk_out("load", 4'd0, 1'b0, 5'd16);
        drv(1'b0, OP_LD, 3'b010, 1'b0, 2'b00, 5'd0); tick();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_stall", stall_cnt, 0);

        // Backpressure: tag 1 held, tag 2 skidded, tag 3 refused
        out_ready = 1'b0;
        drv(1'b1, OP_R, 3'b000, 1'b0, 2'b10, 5'd1); tick();
        chk_out("bp_t1_load", 4'd0, 1'b0, 5'd1);
        chk("bp_e1_in_ready", in_ready, 1);
        drv(1'b1, OP_R, 3'b100, 1'b0, 2'b10, 5'd2); tick();
        chk_out("bp_t1_hold_a", 4'd0, 1'b0, 5'd1);
        chk("bp_skid_in_ready", in_ready, 0);
        drv(1'b1, OP_R, 3'b110, 1'b0, 2'b10, 5'd3); tick();
        chk_out("bp_t1_hold_b", 4'd0, 1'b0, 5'd1);
        tick();
        chk_out("bp_t1_hold_c", 4'd0, 1'b0, 5'd1);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_stall3", stall_cnt, 3);
        out_ready = 1'b1;
        tick(); chk_out("bp_rel_t2", 4'd4, 1'b0, 5'd2);
        chk("bp_rel_in_ready", in_ready, 1);
        tick(); chk_out("bp_rel_t3", 4'd3, 1'b0, 5'd3);
        drv(1'b0, OP_R, 3'b000, 1'b0, 2'b10, 5'd0); tick();
        chk("bp_drained", out_valid, 0);
        chk("bp_stall_kept", stall_cnt, 3);

        // Flush with full skid
        out_ready = 1'b0;
        drv(1'b1, OP_R, 3'b000, 1'b0, 2'b10, 5'd7); tick();
        drv(1'b1, OP_R, 3'b001, 1'b0, 2'b10, 5'd8); tick();
        chk("fl_skid_full", in_ready, 0);
        flush = 1'b1;
        drv(1'b1, OP_R, 3'b010, 1'b0, 2'b10, 5'd9); tick();
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        flush = 1'b0; out_ready = 1'b1;
        drv(1'b1, OP_R, 3'b111, 1'b0, 2'b10, 5'd10); tick();
        chk_out("fl_next_alone", 4'd2, 1'b0, 5'd10);
        drv(1'b0, OP_R, 3'b000, 1'b0, 2'b10, 5'd0); tick();
        chk("fl_no_stale", out_valid, 0);
        chk("fl_stall", stall_cnt, 5);
        flush = 1'b1;
        drv(1'b1, OP_R, 3'b000, 1'b0, 2'b10, 5'd11); tick();
        chk("fl_drop_a", out_valid, 0);
        flush = 1'b0;
        drv(1'b0, OP_R, 3'b000, 1'b0, 2'b10, 5'd0); tick();
        chk("fl_drop_b", out_valid, 0);

        // Saturation, then reset with both entries full
        out_ready = 1'b0;
        drv(1'b1, OP_LUI, 3'b000, 1'b0, 2'b11, 5'd12); tick();
        drv(1'b0, OP_LUI, 3'b000, 1'b0, 2'b11, 5'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_wide", stall_cnt, 25);
        chk("sat_narrow", stall_cnt4, 15);
        drv(1'b1, OP_R, 3'b011, 1'b0, 2'b10, 5'd13); tick();
        chk("sat_narrow_hold", stall_cnt4, 15);
        chk("pre_rst_skid_full", in_ready, 0);
        chk_out("pre_rst_main", 4'd10, 1'b0, 5'd12);
        rst_n = 1'b0; tick();
        chk("mid_rst_outs", {out_valid, ALUControl, illegal, out_tag}, 0);
        chk("mid_rst_stall", {stall_cnt, stall_cnt4}, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        drv(1'b0, OP_R, 3'b000, 1'b0, 2'b10, 5'd0); tick();
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Pipelined, parametrised successor to the single-cycle ALU decoder.
- Decodes op/funct3/funct7_5/ALUOp into a full RV32I ALU control word, plus an illegal-encoding flag.
- Registers the result behind a valid/ready handshake, with a 1-entry skid buffer, flush and a stall counter.
- Sits between the main decoder and the execute stage of the pipelined core.

Parameters:
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width
- ALU_OP_WIDTH, 2, ALUOp width from main decoder
- ALU_CTRL_WIDTH, 4, ALU control word width (must be >=4)
- TAG_WIDTH, 5, opaque sideband carried with each decode (e.g. rd)
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream decode request valid
- in_ready  out  1  stage can accept
- op  in  OP_WIDTH  opcode
- funct3  in  FUNCT3_WIDTH  funct3
- funct7_5  in  1  instruction bit 30
- ALUOp  in  ALU_OP_WIDTH  class from main decoder
- in_tag  in  TAG_WIDTH  sideband
- flush  in  1  discard all held/incoming entries
- out_valid  out  1  result valid
- out_ready  in  1  execute stage accepts
- ALUControl  out  ALU_CTRL_WIDTH  decoded operation
- illegal  out  1  encoding not supported
- out_tag  out  TAG_WIDTH  sideband aligned with ALUControl
- stall_cnt  out  CNT_WIDTH  saturating count of cycles with out_valid && !out_ready

Behaviour:
- Control encoding (zero-extended to ALU_CTRL_WIDTH): ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.
- ALUOp 00 (load/store/auipc): ADD.
- ALUOp 01 (branch) by funct3:
  - 000/001 -> SUB
  - 100/101 -> SLT
  - 110/111 -> SLTU
  - 010/011 -> illegal
- ALUOp 10 (R/I arith) by funct3:
  - 000 -> SUB iff op[5]&&funct7_5, else ADD
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR
  - 101 -> SRA if funct7_5, else SRL (independent of op[5])
  - 110 OR; 111 AND
- ALUOp 11 (lui): PASSB.
- Illegal cases:
  - ALUOp 10, op[5]=1, funct7_5=1, funct3 not in {000,101}
  - ALUOp 10, funct3=001, funct7_5=1
  - branch funct3 010/011
- On illegal: ALUControl=ADD, illegal=1. Otherwise illegal=0.
- Latency: 1 cycle from accepted input (in_valid&&in_ready) to out_valid, when the output register is empty or draining.
- Storage: output register (main) plus skid register.
- in_ready = rst_n && !skid_valid (registered state only; no combinational path from out_ready).
- Handshake, each cycle:
  - Main empty or out_ready: main loads skid if skid valid, else the accepted input. Skid clears.
  - Main full and !out_ready and input accepted: input goes to skid.
- Throughput: 1/cycle with out_ready held high.
- out_* stable while out_valid && !out_ready.
- flush (priority over all else): next cycle out_valid=0, skid empty. An input accepted in the flush cycle is dropped. stall_cnt is unaffected.
- Simultaneous accept + drain with skid empty: main reloads from input, no bubble.
- stall_cnt increments on each stall cycle and saturates at all-ones without wrap.
- Reset (rst_n=0 at clk edge):
  - out_valid=0, skid_valid=0, ALUControl=0, illegal=0, out_tag=0, stall_cnt=0.
  - in_ready=0 while rst_n low.
  - Reset mid-transfer discards held entries.

Decomposition:
- Package alu_ctrl_pkg:
  - alu_ctrl_e enum (the 11 encodings above)
  - ALUOp class localparams (ALUOP_MEM, ALUOP_BRANCH, ALUOP_ARITH, ALUOP_LUI)
- Sub-module alu_decode_comb: purely combinational op/funct3/funct7_5/ALUOp -> {ALUControl, illegal}, instantiated on the input side.
- The stage itself holds only handshake, skid and counter logic.

Test Plan:
- Reset then R-type stream:
  - Stimulus: op=0110011, ALUOp=10, out_ready=1; funct3/funct7_5 = 000/1, 000/0, 101/1, 101/0, 111/0.
  - Required: SUB,ADD,SRA,SRL,AND on consecutive cycles, 1 cycle after each accept, illegal=0.
- I-type and immediate shifts:
  - addi with funct7_5=1 (op=0010011, funct3 000) -> ADD.
  - srai (funct3 101, f7_5=1) -> SRA.
  - slli with f7_5=1 -> illegal=1, ALUControl=0.
- Branches and other classes:
  - ALUOp=01 with funct3 000,100,110,011 -> SUB,SLT,SLTU,illegal.
  - ALUOp=11 -> 10 (PASSB).
  - ALUOp=00 -> 0 (ADD).
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while in_valid=1 with tags 1,2,3.
  - Required:
    - tag 1 holds on output
    - tag 2 in skid; in_ready=0 from next cycle
    - tag 3 not accepted
    - stall_cnt increments by 3
  - On release: tags 1,2,3 emerge in order, no loss or duplication.
- Flush with full skid:
  - Required: next cycle out_valid=0 and in_ready=1; the next accepted input appears alone.
- Saturation and mid-operation reset:
  - CNT_WIDTH=4 with 20 stall cycles -> stall_cnt=15.
  - rst_n=0 for one edge with both entries full -> all outputs 0, in_ready=1 after release.
